// File: rtl/wb_commit_unit.sv
// wb_commit_unit -- writeback / commit stage.
//
// Holds the MEM/WB pipeline register behind a valid/ready handshake, waits
// for late load data from a multi-cycle data memory, and drives the
// register-file write port. Also exports bypass and pending-load hazard
// information to decode, plus a sticky halt flag.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   PC_in, WBSel_in, ALUOutput_in, Immediate_in, Rdst_in, halt_in
//                       instruction fields latched on accept
//   load_valid/load_data late load result (sampled only in WAIT_MEM)
//   Rw_out, Di_out, rf_we   register-file write port
//   fwd_valid           Rw_out/Di_out usable for bypass
//   pending/pending_rd  load in flight and its destination
//   halted              sticky halt flag
//   retire_count        commit-cycle counter (only with WB_RETIRE_CNT_EN)
//
// Optional feature macro: WB_RETIRE_CNT_EN adds the 64-bit retire_count output.
module wb_commit_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_INC     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       PC_in,
    input  logic [1:0]            WBSel_in,
    input  logic [XLEN-1:0]       ALUOutput_in,
    input  logic [XLEN-1:0]       Immediate_in,
    input  logic [REG_ADDR_W-1:0] Rdst_in,
    input  logic                  halt_in,
    input  logic                  load_valid,
    input  logic [XLEN-1:0]       load_data,
    output logic [REG_ADDR_W-1:0] Rw_out,
    output logic [XLEN-1:0]       Di_out,
    output logic                  rf_we,
    output logic                  fwd_valid,
    output logic                  pending,
    output logic [REG_ADDR_W-1:0] pending_rd,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]           retire_count,
`endif
    output logic                  halted
);

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, HALTED} state_t;

    state_t                  state_q, state_d;
    logic [XLEN-1:0]         pc_q, alu_q, imm_q, ld_q;
    logic [1:0]              wbsel_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic                    halt_q;
    logic                    accept;
    logic                    ld_take;

    assign in_ready = (state_q == IDLE) || (state_q == COMMIT);
    assign accept   = in_valid && in_ready;
    assign ld_take  = (state_q == WAIT_MEM) && load_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COMMIT: begin
                // COMMIT falls back to IDLE unless a new instruction arrives
                // in the same cycle, giving one instruction per cycle.
                if (accept) begin
                    if (halt_in)                 state_d = HALTED;
                    else if (WBSel_in == WB_MEM) state_d = WAIT_MEM;
                    else                         state_d = COMMIT;
                end else if (state_q == COMMIT) begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: if (load_valid) state_d = COMMIT;
            HALTED:   state_d = HALTED;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q    <= '0;
            alu_q   <= '0;
            imm_q   <= '0;
            ld_q    <= '0;
            wbsel_q <= '0;
            rd_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            if (accept) begin
                pc_q    <= PC_in;
                alu_q   <= ALUOutput_in;
                imm_q   <= Immediate_in;
                wbsel_q <= WBSel_in;
                rd_q    <= Rdst_in;
                halt_q  <= halt_in;
            end
            if (ld_take) ld_q <= load_data;
        end
    end

    always_comb begin
        Di_out = alu_q;
        case (wbsel_q)
            WB_ALU:  Di_out = alu_q;
            WB_PC4:  Di_out = pc_q + XLEN'(PC_INC);
            WB_MEM:  Di_out = ld_q;
            WB_IMM:  Di_out = imm_q;
            default: Di_out = alu_q;
        endcase
    end

    // A held halt never names a destination, so it can never write.
    assign Rw_out     = halt_q ? '0 : rd_q;
    assign rf_we      = (state_q == COMMIT) && (Rw_out != '0);
    assign fwd_valid  = rf_we;
    assign pending    = (state_q == WAIT_MEM) && (rd_q != '0);
    assign pending_rd = (state_q == WAIT_MEM) ? rd_q : '0;
    assign halted     = (state_q == HALTED);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_q;

    // Counts every commit cycle, x0 writes included; halts never reach COMMIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                    retire_q <= '0;
        else if (state_q == COMMIT)  retire_q <= retire_q + 64'd1;
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Parametrised successor to the combinational writeback stage.
- Holds the MEM/WB pipeline register and accepts instructions over a valid/ready handshake.
- Waits for late load data from a multi-cycle data memory and drives the register-file write port.
- Also provides forwarding/pending-hazard information to decode, and a sticky halt state.

Parameters:
XLEN, 32, datapath width of PC, ALU, immediate, load and writeback data
REG_ADDR_W, 5, register-file address width; register 0 is hard-wired zero
PC_INC, 4, increment added to PC for WBSel=PC4 (link value)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  unit can accept this cycle
PC_in  input  XLEN  instruction PC
WBSel_in  input  2  00 ALU, 01 PC+PC_INC, 10 Mem, 11 Imm
ALUOutput_in  input  XLEN  ALU result
Immediate_in  input  XLEN  immediate
Rdst_in  input  REG_ADDR_W  destination register
halt_in  input  1  instruction is a halt
load_valid  input  1  load_data valid this cycle
load_data  input  XLEN  extended load result
Rw_out  output  REG_ADDR_W  register-file write address
Di_out  output  XLEN  register-file write data
rf_we  output  1  active-high register-file write strobe
fwd_valid  output  1  Rw_out/Di_out valid for bypass
pending  output  1  load in flight to pending_rd
pending_rd  output  REG_ADDR_W  destination of in-flight load
halted  output  1  sticky halt flag

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT, HALTED. Reset (RST=0, asynchronous) forces IDLE and clears all held fields to 0. Every output is 0 in reset except in_ready=1.
- in_ready = 1 in IDLE and COMMIT; 0 in WAIT_MEM and HALTED.
- Accept = in_valid & in_ready at a rising edge. Accepting latches PC, WBSel, ALU, Imm, Rdst and halt.
- Next state after accept:
  - halt_in=1 -> HALTED.
  - else WBSel=Mem -> WAIT_MEM.
  - else -> COMMIT.
- COMMIT with no accept in the same cycle -> IDLE. COMMIT with an accept -> the state selected by the new instruction (full throughput of 1 instruction/cycle).
- WAIT_MEM: on the first edge with load_valid=1, latch load_data and go to COMMIT. load_valid is ignored in every other state.
- Di_out selection from held fields:
  - ALU -> ALUOutput.
  - PC4 -> (PC + PC_INC) mod 2^XLEN.
  - Mem -> latched load data.
  - Imm -> Immediate.
- Di_out and Rw_out are driven from held state in every state. Rw_out is forced to 0 when the held halt bit is 1.
- rf_we = (state==COMMIT) & (Rw_out != 0). A write to x0 never asserts rf_we. fwd_valid equals rf_we.
- pending = (state==WAIT_MEM) & (held Rdst != 0). pending_rd = held Rdst while in WAIT_MEM, else 0.
- Latency:
  - Non-load accepted at edge N: rf_we is high during cycle N..N+1 and the register file writes at edge N+1.
  - Load: write occurs the edge after the edge that samples load_valid.
- HALTED: sticky until reset. in_ready=0, halted=1, rf_we=0. A halt instruction never writes.
- Reset asserted mid-WAIT_MEM or COMMIT: the instruction is dropped and no write occurs. A load_valid arriving after reset is ignored.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count (64 bits), reset to 0.
  - Increments by 1 on every cycle in COMMIT, including writes to x0.
  - Halt instructions are not counted. Wraps modulo 2^64.
- When undefined: the port and counter do not exist and all other behaviour is identical.

Test Plan:
- Reset held, then released; push ALU op (ALUOutput=0x0000_1234, Rdst=5) -> next cycle rf_we=1, Rw_out=5, Di_out=0x1234, fwd_valid=1; following idle cycle rf_we=0.
- Back-to-back: in_valid high 3 cycles, WBSel=PC4 with PC=0xFFFF_FFFC then Imm 0xABCD then ALU 7 -> consecutive rf_we pulses, Di_out=0x0000_0000 (wrap), 0xABCD, 7; in_ready stays 1.
- Load Rdst=9, load_valid delayed 3 cycles with load_data=0xDEAD_BEEF -> pending=1 and pending_rd=9 for 3 cycles, in_ready=0; one cycle later rf_we=1 with Di_out=0xDEADBEEF.
- Write to Rdst=0 via ALU 0x55 -> rf_we=0, fwd_valid=0 (retire_count still +1 with WB_RETIRE_CNT_EN).
- Halt accepted, then in_valid held high with an ALU op -> halted=1 forever, in_ready=0, rf_we never asserted, Rw_out=0; pulse RST low -> IDLE, halted=0.
- RST low asynchronously during WAIT_MEM, load_valid pulsed after release -> no rf_we, pending=0.
